// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state encoding and note-table entry layout
package note_seq_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
  localparam int N_W = 10;
  localparam int VOL_W = 8;
  localparam int DUR_W = 8;
  localparam int DUR_LSB = 0;
  localparam int VOL_LSB = DUR_LSB + DUR_W;
  localparam int N_LSB = VOL_LSB + VOL_W;
  localparam int ENTRY_W = N_W + VOL_W + DUR_W;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running 0..TICK_DIV-1 counter, tick high on the wrap cycle
module tick_prescaler #(
  parameter int TICK_DIV = 50000,
  localparam int W = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  // count up, wrap on tick, hold at zero while cleared
  always_ff @(posedge clk)
    if (!rst_n || clear) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a register-file note table as N/volume pairs with gaps
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TICK_DIV = 50000,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [N_W-1:0]     N,
  output logic [VOL_W-1:0]   volume,
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      note_idx
);
  state_t state, state_nx;
  logic [ENTRY_W-1:0] table_q [DEPTH];
  logic [IW-1:0] idx_nx;
  logic [DUR_W-1:0] dcnt;
  logic [VOL_W-1:0] vol_q;
  logic done_nx, tick;
  logic [ENTRY_W-1:0] entry;
  logic [DUR_W-1:0] e_dur;
  assign entry = table_q[note_idx];
  assign e_dur = entry[DUR_LSB +: DUR_W];
  assign busy = state != IDLE;
  assign volume = state == PLAY ? vol_q : '0;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE || state == LOAD),
    .tick  (tick)
  );
  // next state, next index and completion pulse; stop overrides everything when busy
  always_comb begin
    state_nx = state;
    idx_nx = note_idx;
    done_nx = 1'b0;
    if (stop && state != IDLE) state_nx = IDLE;
    else
      case (state)
        IDLE: if (start && !stop) begin
          state_nx = LOAD;
          idx_nx = '0;
        end
        LOAD: if (e_dur != '0) state_nx = PLAY;
        else if (loop_en && note_idx != '0) idx_nx = '0;
        else begin
          state_nx = IDLE;
          done_nx = 1'b1;
        end
        PLAY: if (tick && dcnt == DUR_W'(1)) state_nx = GAP;
        GAP: if (tick) begin
          if (note_idx != IW'(DEPTH - 1)) begin
            state_nx = LOAD;
            idx_nx = note_idx + IW'(1);
          end else if (loop_en) begin
            state_nx = LOAD;
            idx_nx = '0;
          end else begin
            state_nx = IDLE;
            done_nx = 1'b1;
          end
        end
      endcase
  end
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // datapath: index, latched note, duration countdown, table writes while idle
  always_ff @(posedge clk)
    if (!rst_n) begin
      note_idx <= '0;
      N <= '0;
      vol_q <= '0;
      dcnt <= '0;
      done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else begin
      note_idx <= idx_nx;
      done <= done_nx;
      if (state == LOAD && e_dur != '0) begin
        N <= entry[N_LSB +: N_W];
        vol_q <= entry[VOL_LSB +: VOL_W];
        dcnt <= e_dur;
      end else if (state == PLAY && tick) dcnt <= dcnt - DUR_W'(1);
      if (wr_en && state == IDLE) table_q[wr_addr] <= wr_data;
    end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of note_sequencer with DEPTH=4, TICK_DIV=4
module tb_note_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [25:0] wr_data = '0;
  logic [9:0] N;
  logic [7:0] volume;
  logic busy, done;
  logic [1:0] note_idx;
  int n_chk = 0, n_pass = 0;
  note_sequencer #(.DEPTH(4), .TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .N(N), .volume(volume), .busy(busy), .done(done), .note_idx(note_idx)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic hold(input string tag, input int n, input int en, input int ev,
                      input int ei, input int eb, input int ed);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.N[%0d]", tag, i), 32'(N), en);
      check($sformatf("%s.vol[%0d]", tag, i), 32'(volume), ev);
      check($sformatf("%s.idx[%0d]", tag, i), 32'(note_idx), ei);
      check($sformatf("%s.busy[%0d]", tag, i), 32'(busy), eb);
      check($sformatf("%s.done[%0d]", tag, i), 32'(done), ed);
      step();
    end
  endtask
  task automatic wr(input logic [1:0] a, input int n, input int v, input int d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = {10'(n), 8'(v), 8'(d)};
    step();
    wr_en = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    step();
    step();
    hold("reset", 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    // empty table: one LOAD cycle then done
    pulse_start();
    hold("empty", 1, 0, 0, 0, 1, 0);
    hold("empty_end", 1, 0, 0, 0, 0, 1);
    hold("empty_after", 1, 0, 0, 0, 0, 0);
    loop_en = 1'b1;
    pulse_start();
    hold("empty_loop", 1, 0, 0, 0, 1, 0);
    hold("empty_loop_end", 1, 0, 0, 0, 0, 1);
    loop_en = 1'b0;
    // two notes then end marker
    wr(2'd0, 50, 7, 2);
    wr(2'd1, 100, 20, 1);
    pulse_start();
    hold("t36_load0", 1, 0, 0, 0, 1, 0);
    hold("t36_play0", 8, 50, 7, 0, 1, 0);
    hold("t36_gap0", 4, 50, 0, 0, 1, 0);
    hold("t36_load1", 1, 50, 0, 1, 1, 0);
    hold("t36_play1", 4, 100, 20, 1, 1, 0);
    hold("t36_gap1", 4, 100, 0, 1, 1, 0);
    hold("t36_end", 1, 100, 0, 2, 1, 0);
    hold("t36_done", 1, 100, 0, 2, 0, 1);
    hold("t36_idle", 1, 100, 0, 2, 0, 0);
    // looping, then stop mid-note
    loop_en = 1'b1;
    pulse_start();
    hold("t37_load0", 1, 100, 0, 0, 1, 0);
    hold("t37_play0", 8, 50, 7, 0, 1, 0);
    hold("t37_gap0", 4, 50, 0, 0, 1, 0);
    hold("t37_load1", 1, 50, 0, 1, 1, 0);
    hold("t37_play1", 4, 100, 20, 1, 1, 0);
    hold("t37_gap1", 4, 100, 0, 1, 1, 0);
    hold("t37_end", 1, 100, 0, 2, 1, 0);
    hold("t37_reload", 1, 100, 0, 0, 1, 0);
    start = 1'b1;
    hold("t37_replay", 3, 50, 7, 0, 1, 0);
    start = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    hold("t37_stop", 2, 50, 0, 0, 0, 0);
    loop_en = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    hold("start_stop", 1, 50, 0, 0, 0, 0);
    // four short notes, index wrap ends playback
    for (int i = 0; i < 4; i++) wr(2'(i), i + 1, 10 + i, 1);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      hold($sformatf("t39_load%0d", i), 1, i == 0 ? 50 : i, 0, i, 1, 0);
      hold($sformatf("t39_play%0d", i), 4, i + 1, 10 + i, i, 1, 0);
      hold($sformatf("t39_gap%0d", i), 4, i + 1, 0, i, 1, 0);
    end
    hold("t39_done", 1, 4, 0, 3, 0, 1);
    hold("t39_idle", 1, 4, 0, 3, 0, 0);
    // write while busy is dropped; reset mid-play
    wr(2'd0, 50, 7, 2);
    wr(2'd1, 100, 20, 1);
    wr(2'd2, 0, 0, 0);
    pulse_start();
    hold("t40_load0", 1, 4, 0, 0, 1, 0);
    hold("t40_play0a", 2, 50, 7, 0, 1, 0);
    wr_en = 1'b1;
    wr_addr = 2'd1;
    wr_data = {10'd300, 8'd99, 8'd1};
    hold("t40_play0b", 1, 50, 7, 0, 1, 0);
    wr_en = 1'b0;
    hold("t40_play0c", 5, 50, 7, 0, 1, 0);
    hold("t40_gap0", 4, 50, 0, 0, 1, 0);
    hold("t40_load1", 1, 50, 0, 1, 1, 0);
    hold("t40_play1", 2, 100, 20, 1, 1, 0);
    rst_n = 1'b0;
    start = 1'b1;
    wr_en = 1'b1;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    hold("t40_reset", 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    // table cleared by reset
    pulse_start();
    hold("cleared_load", 1, 0, 0, 0, 1, 0);
    hold("cleared_done", 1, 0, 0, 0, 0, 1);
    // write and start together: new value plays
    wr_en = 1'b1;
    wr_addr = 2'd0;
    wr_data = {10'd77, 8'd5, 8'd1};
    start = 1'b1;
    step();
    wr_en = 1'b0;
    start = 1'b0;
    hold("wrstart_load", 1, 0, 0, 0, 1, 0);
    hold("wrstart_play", 4, 77, 5, 0, 1, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    hold("wrstart_stop", 1, 77, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
